// File: rtl/arb_burst_pkg.sv
// Shared helpers for the arbiter burst FIFO slice.
// Provides the burst length clamp used when a burst starts.
package arb_burst_pkg;

   // The burst length is clamped into the range 1..max_len.
   function automatic int unsigned clamp_len(
      input int unsigned len,
      input int unsigned max_len
   );
      if (len == 0) return 1;
      if (len > max_len) return max_len;
      return len;
   endfunction

endpackage

// File: rtl/arb_burst_ctr.sv
// Burst beat counter and round-robin lock for the arbiter burst FIFO.
// Ports: clk_i, rst_i, flush_i, push_i, idx_i, burst_len_i -> lock_rr_o, burst_err_o.
module arb_burst_ctr
   import arb_burst_pkg::*;
#(
   parameter int MaxBurst   = 8,
   parameter int IdxWidth   = 3,
   parameter int BurstWidth = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic [IdxWidth-1:0]   idx_i,
   input  logic [BurstWidth-1:0] burst_len_i,
   output logic                  lock_rr_o,
   output logic                  burst_err_o
);

   logic [BurstWidth-1:0] cnt_q;
   logic [BurstWidth-1:0] len_q;
   logic [IdxWidth-1:0]   burst_idx_q;
   logic                  lock_q;
   logic                  err_q;

   logic [BurstWidth-1:0] len_new;
   logic [BurstWidth-1:0] len_eff;
   logic [BurstWidth-1:0] cnt_inc;
   logic [BurstWidth-1:0] cnt_nxt;
   logic                  first_beat;

   always_comb begin
      first_beat = (cnt_q == '0);
      len_new    = BurstWidth'(clamp_len(32'(burst_len_i), MaxBurst));
      // The first beat compares against the length being latched now.
      len_eff    = first_beat ? len_new : len_q;
      cnt_inc    = cnt_q + 1'b1;
      cnt_nxt    = cnt_q;
      if (push_i) begin
         cnt_nxt = (cnt_inc == len_eff) ? '0 : cnt_inc;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         cnt_q       <= '0;
         len_q       <= '0;
         burst_idx_q <= '0;
         lock_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         cnt_q  <= cnt_nxt;
         // Lock is a register so the arbiter sees no input-to-output path.
         lock_q <= (cnt_nxt != '0);
         if (push_i && first_beat) begin
            len_q       <= len_new;
            burst_idx_q <= idx_i;
         end
         if (push_i && !first_beat && (idx_i != burst_idx_q)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign lock_rr_o   = lock_q;
   assign burst_err_o = err_q;

endmodule

// File: rtl/arb_burst_fifo.sv
// Burst-aware output FIFO behind the locking round-robin arbiter tree.
// Ports: beat in (valid_i/ready_o/data_i/idx_i/burst_len_i), head out
// (valid_o/ready_i/data_o/idx_o), usage_o, lock_rr_o, burst_err_o, flush_i.
module arb_burst_fifo
   import arb_burst_pkg::*;
#(
   parameter int NumIn      = 7,
   parameter int DataWidth  = 45,
   parameter int Depth      = 4,
   parameter int MaxBurst   = 8,
   localparam int IdxWidth   = (NumIn > 1) ? $clog2(NumIn) : 1,
   localparam int BurstWidth = $clog2(MaxBurst + 1),
   localparam int PtrWidth   = $clog2(Depth),
   localparam int UsageWidth = $clog2(Depth) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [BurstWidth-1:0] burst_len_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DataWidth-1:0]  data_i,
   input  logic [IdxWidth-1:0]   idx_i,
   output logic                  lock_rr_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DataWidth-1:0]  data_o,
   output logic [IdxWidth-1:0]   idx_o,
   output logic [UsageWidth-1:0] usage_o,
   output logic                  burst_err_o
);

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic [IdxWidth-1:0]  idx;
   } entry_t;

   entry_t                mem_q [Depth];
   logic [PtrWidth-1:0]   wr_ptr_q;
   logic [PtrWidth-1:0]   rd_ptr_q;
   logic [UsageWidth-1:0] usage_q;

   logic   full;
   logic   empty;
   logic   push;
   logic   pop;
   entry_t head;

   assign full  = (usage_q == UsageWidth'(Depth));
   assign empty = (usage_q == '0);

   // Readiness depends on this cycle's occupancy only, never on a pop.
   assign ready_o = !full && !rst_i && !flush_i;
   assign push    = valid_i && ready_o;
   assign pop     = !empty && ready_i && !rst_i && !flush_i;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{data: data_i, idx: idx_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usage_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   usage_q <= usage_q + 1'b1;
            2'b01:   usage_q <= usage_q - 1'b1;
            default: usage_q <= usage_q;
         endcase
      end
   end

   // Storage is not reset, so the head is masked to zero when empty.
   assign head    = mem_q[rd_ptr_q];
   assign valid_o = !empty;
   assign data_o  = valid_o ? head.data : '0;
   assign idx_o   = valid_o ? head.idx : '0;
   assign usage_o = usage_q;

   arb_burst_ctr #(
      .MaxBurst   (MaxBurst),
      .IdxWidth   (IdxWidth),
      .BurstWidth (BurstWidth)
   ) u_ctr (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .push_i      (push),
      .idx_i       (idx_i),
      .burst_len_i (burst_len_i),
      .lock_rr_o   (lock_rr_o),
      .burst_err_o (burst_err_o)
   );

endmodule
